// File: rtl/vsub_pipe.sv
// vsub_pipe: two-stage packed-lane vector subtractor, c = a - b per lane.
// Ports: clk, rst_n, in_valid/in_ready/a/b/sat in, out_valid/out_ready/c/borrow/ovf out.
module vsub_pipe #(
  parameter int LANE_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  input  logic                       sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          c,
  output logic [DATA_W/LANE_W-1:0]   borrow,
  output logic [DATA_W/LANE_W-1:0]   ovf
);

  localparam int NL = DATA_W / LANE_W;

  localparam logic [LANE_W-1:0] LMAX =
    {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LMIN =
    {1'b1, {(LANE_W-1){1'b0}}};

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_sat;
  logic              s2_valid;

  logic              s1_adv;
  logic              s2_adv;

  logic [DATA_W-1:0] c_n;
  logic [NL-1:0]     bo_n;
  logic [NL-1:0]     ov_n;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sat   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sat <= sat;
      end
    end
  end

  // Each lane gets its own LANE_W+1 bit subtract so no borrow
  // can leak into the neighbouring lane.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LANE_W-1:0] al;
    logic [LANE_W-1:0] bl;
    logic [LANE_W-1:0] wr;
    logic [LANE_W:0]   d;

    assign al = s1_a[i*LANE_W +: LANE_W];
    assign bl = s1_b[i*LANE_W +: LANE_W];
    assign d  = {1'b0, al} - {1'b0, bl};
    assign wr = d[LANE_W-1:0];

    assign bo_n[i] = d[LANE_W];
    // Signs differ and the result sign left the minuend's sign.
    assign ov_n[i] = (al[LANE_W-1] != bl[LANE_W-1]) &
                     (wr[LANE_W-1] != al[LANE_W-1]);

    assign c_n[i*LANE_W +: LANE_W] =
      (s1_sat & ov_n[i]) ? (al[LANE_W-1] ? LMIN : LMAX) : wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      c        <= '0;
      borrow   <= '0;
      ovf      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        c      <= c_n;
        borrow <= bo_n;
        ovf    <= ov_n;
      end
    end
  end

endmodule
